// File: rtl/clk_div_sel_pkg.sv
// Shared constants for the divider and the downstream LED/display experiments.
//   CLK_HZ      board clock frequency
//   SEL_W       width of the ratio selector
//   HALF_*HZ    default half-periods (in clk cycles) for 1/2/4/8 Hz
//   speed_e     named ratio indices used on the selector
package clk_div_sel_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned SEL_W  = 2;

  // Half-period in clk cycles for a square wave of the given frequency.
  function automatic int unsigned half_for_hz(input int unsigned hz);
    return CLK_HZ / (2 * hz);
  endfunction

  localparam int unsigned HALF_1HZ = half_for_hz(1);
  localparam int unsigned HALF_2HZ = half_for_hz(2);
  localparam int unsigned HALF_4HZ = half_for_hz(4);
  localparam int unsigned HALF_8HZ = half_for_hz(8);

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [SEL_W-1:0] {
    SPEED_1HZ = 2'd0,
    SPEED_2HZ = 2'd1,
    SPEED_4HZ = 2'd2,
    SPEED_8HZ = 2'd3
  } speed_e;

endpackage

// File: rtl/clk_div_sel.sv
// Programmable frequency divider with glitch-free ratio switching.
//   clk        board clock, all logic on posedge
//   reset      synchronous, active-low
//   en         1 = run, 0 = freeze counter/clk_out/act_sel (tick forced low)
//   speed_sel  requested ratio index, adopted only at the end of a full period
//   clk_out    divided clock, 50 % duty, period 2*HALFn
//   tick       one-cycle pulse with each rising edge of clk_out
module clk_div_sel
  import clk_div_sel_pkg::*;
#(
  parameter int unsigned CNT_W = 26,
  parameter int unsigned HALF0 = HALF_1HZ,
  parameter int unsigned HALF1 = HALF_2HZ,
  parameter int unsigned HALF2 = HALF_4HZ,
  parameter int unsigned HALF3 = HALF_8HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  sel_t speed_sel,
  output logic clk_out,
  output logic tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] last;
  speed_e           act_sel;

  always_comb begin
    half = CNT_W'(HALF0);
    unique case (act_sel)
      SPEED_1HZ: half = CNT_W'(HALF0);
      SPEED_2HZ: half = CNT_W'(HALF1);
      SPEED_4HZ: half = CNT_W'(HALF2);
      SPEED_8HZ: half = CNT_W'(HALF3);
      default:   half = CNT_W'(HALF0);
    endcase
  end

  assign last = half - CNT_W'(1);

  // act_sel only moves on the falling toggle of clk_out, so a period
  // always completes with the ratio it started with.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      act_sel <= speed_e'(speed_sel);
    end else if (en) begin
      if (cnt == last) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
        if (clk_out)
          act_sel <= speed_e'(speed_sel);
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clk_div_sel.sv
module tb_clk_div_sel;

  logic       clk = 1'b0;
  logic       reset, en;
  logic [1:0] speed_sel;
  logic       clk_out, tick;
  logic       reset1;
  logic       clk_out1, tick1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_div_sel #(.CNT_W(4), .HALF0(2), .HALF1(3), .HALF2(5), .HALF3(8)) dut (
    .clk(clk), .reset(reset), .en(en), .speed_sel(speed_sel),
    .clk_out(clk_out), .tick(tick)
  );

  clk_div_sel #(.CNT_W(4), .HALF0(1), .HALF1(3), .HALF2(5), .HALF3(8)) dut1 (
    .clk(clk), .reset(reset1), .en(1'b1), .speed_sel(2'd0),
    .clk_out(clk_out1), .tick(tick1)
  );

  // Reference model: position within the current full period (0..2h-1).
  // clk_out is high in the second half of the period.
  int HALF_T[4] = '{2, 3, 5, 8};
  int m_pos, m_act, m_tick, m_clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] s);
    int h;
    reset = r; en = e; speed_sel = s;
    @(posedge clk);
    #1;
    if (!r) begin
      m_pos = 0; m_act = int'(s); m_tick = 0;
    end else if (e) begin
      h = HALF_T[m_act];
      m_pos++;
      if (m_pos == 2 * h) begin
        m_pos = 0; m_act = int'(s);
      end
      m_tick = (m_pos == h) ? 1 : 0;
    end else begin
      m_tick = 0;
    end
    m_clk = (m_pos >= HALF_T[m_act]) ? 1 : 0;
    chk("model_clk_out", int'(clk_out), m_clk);
    chk("model_tick", int'(tick), m_tick);
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [1:0] s;
    logic       xclk;
    logic       xtick;
  } vec_t;

  vec_t tbl[13];
  int   hi_cnt, tk_cnt, last_tk, gap;
  int   cv[16];
  int   tv[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b1; speed_sel = 2'd0; reset1 = 1'b0;
    m_pos = 0; m_act = 0; m_tick = 0; m_clk = 0;

    // Reset then sel=0: clk_out 0,0,1,1,0,0,... tick at 2,6,10
    tbl[0] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    for (int i = 1; i < 13; i++) begin
      tbl[i].r = 1'b1; tbl[i].e = 1'b1; tbl[i].s = 2'd0;
      tbl[i].xclk  = ((i % 4) == 2 || (i % 4) == 3) ? 1'b1 : 1'b0;
      tbl[i].xtick = ((i % 4) == 2) ? 1'b1 : 1'b0;
    end
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].s);
      chk($sformatf("tbl_clk[%0d]", i), int'(clk_out), int'(tbl[i].xclk));
      chk($sformatf("tbl_tick[%0d]", i), int'(tick), int'(tbl[i].xtick));
    end

    // sel=3 steady: period 16, high 8, one tick per 16
    step(1'b0, 1'b1, 2'd3);
    hi_cnt = 0; tk_cnt = 0; last_tk = -1; gap = 0;
    for (int c = 1; c <= 48; c++) begin
      step(1'b1, 1'b1, 2'd3);
      if (clk_out) hi_cnt++;
      if (tick) begin
        if (last_tk >= 0) gap = c - last_tk;
        if (last_tk < 0) chk("sel3_first_rise", c, 8);
        last_tk = c;
        tk_cnt++;
      end
    end
    chk("sel3_high_cycles", hi_cnt, 24);
    chk("sel3_ticks", tk_cnt, 3);
    chk("sel3_period", gap, 16);

    // sel 0->2 while clk_out=1: finish at half=2, next period 10
    step(1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 2'd0);
    chk("chg_clk_c2", int'(clk_out), 1);
    for (int c = 3; c <= 14; c++) begin
      step(1'b1, 1'b1, 2'd2);
      cv[c] = int'(clk_out); tv[c] = int'(tick);
    end
    chk("chg_clk_c3", cv[3], 1);
    chk("chg_clk_c4", cv[4], 0);
    chk("chg_clk_c8", cv[8], 0);
    chk("chg_clk_c9", cv[9], 1);
    chk("chg_tick_c9", tv[9], 1);
    chk("chg_clk_c13", cv[13], 1);
    chk("chg_clk_c14", cv[14], 0);

    // Freeze at cnt=1 for 7 cycles, resume toggles 1 cycle later
    step(1'b0, 1'b1, 2'd0);
    step(1'b1, 1'b1, 2'd0);
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 1'b0, 2'd0);
      chk("frz_clk", int'(clk_out), 0);
      chk("frz_tick", int'(tick), 0);
    end
    step(1'b1, 1'b1, 2'd0);
    chk("frz_resume_clk", int'(clk_out), 1);
    chk("frz_resume_tick", int'(tick), 1);

    // Reset mid-period while clk_out=1
    step(1'b1, 1'b1, 2'd0);
    chk("rst_pre_clk", int'(clk_out), 1);
    step(1'b0, 1'b1, 2'd0);
    chk("rst_clk", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    step(1'b1, 1'b1, 2'd0);
    chk("rst_c1_clk", int'(clk_out), 0);
    step(1'b1, 1'b1, 2'd0);
    chk("rst_c2_clk", int'(clk_out), 1);
    chk("rst_c2_tick", int'(tick), 1);

    // HALF0=1 build: toggles every cycle, tick on every rise
    reset1 = 1'b0;
    step(1'b1, 1'b1, 2'd0);
    chk("h1_rst_clk", int'(clk_out1), 0);
    reset1 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(1'b1, 1'b1, 2'd0);
      chk($sformatf("h1_clk[%0d]", c), int'(clk_out1), c % 2);
      chk($sformatf("h1_tick[%0d]", c), int'(tick1), c % 2);
    end

    // Randomized run against the model
    step(1'b0, 1'b1, 2'd0);
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 200) != 0, ($urandom % 6) != 0, 2'($urandom % 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
